// File: rtl/tcm_flash_sequencer.sv
// Avalon-MM slave to tri-state conduit sequencer for an 8-bit parallel flash.
// Each command runs SETUP -> WAIT -> HOLD with registered pad-side outputs.
module tcm_flash_sequencer #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned WAIT_CYCLES  = 6,
  parameter int unsigned HOLD_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [22:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [7:0]  avs_writedata,
  output logic        avs_waitrequest,
  output logic [7:0]  avs_readdata,
  output logic        avs_readdatavalid,
  output logic [22:0] tcm_address_out,
  output logic        tcm_read_n_out,
  output logic        tcm_write_n_out,
  output logic        tcm_chipselect_n_out,
  output logic [7:0]  tcm_data_out,
  output logic        tcm_data_outen,
  input  logic [7:0]  tcm_data_in
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] WAIT_LD  = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] HOLD_LD  = (HOLD_CYCLES == 0) ? 4'd0 : 4'(HOLD_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [22:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdv_q, rdv_d;
  logic        cs_n_q, cs_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        outen_q, outen_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 4'd1 : cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    rdv_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (avs_read || avs_write) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          wr_d    = ~avs_read;
          addr_d  = avs_address;
          dout_d  = avs_writedata;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (!wr_q) begin
            rdata_d = tcm_data_in;
            rdv_d   = 1'b1;
          end
          state_d = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      default: begin
        if (cnt_q == '0) state_d = ST_IDLE;
      end
    endcase
    // Pad controls are decoded from the next state so they change on the same edge as the FSM.
    cs_n_d  = (state_d == ST_IDLE);
    rd_n_d  = !((state_d == ST_WAIT) && !wr_d);
    wr_n_d  = !((state_d == ST_WAIT) && wr_d);
    outen_d = (state_d != ST_IDLE) && wr_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      outen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      outen_q <= outen_d;
    end
  end

  assign avs_waitrequest      = reset || (state_q != ST_IDLE);
  assign avs_readdata         = rdata_q;
  assign avs_readdatavalid    = rdv_q;
  assign tcm_address_out      = addr_q;
  assign tcm_read_n_out       = rd_n_q;
  assign tcm_write_n_out      = wr_n_q;
  assign tcm_chipselect_n_out = cs_n_q;
  assign tcm_data_out         = dout_q;
  assign tcm_data_outen       = outen_q;

endmodule

// File: tb/tb_tcm_flash_sequencer.sv
// Bench for tcm_flash_sequencer: two parameterisations, a behavioural flash pad,
// per-cycle transaction profiles and a memory scoreboard.
module tb_tcm_flash_sequencer;

  localparam int S0 = 2, W0 = 6, H0 = 2;
  localparam int S1 = 1, W1 = 1, H1 = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [22:0] a_i [2];
  logic        rd_i [2], wr_i [2];
  logic [7:0]  wd_i [2], din [2];
  logic        wreq [2], rdv [2], cs_n [2], rd_n [2], wr_n [2], oen [2];
  logic [7:0]  rdat [2], dout [2];
  logic [22:0] a_o [2];

  tcm_flash_sequencer #(.SETUP_CYCLES(S0), .WAIT_CYCLES(W0), .HOLD_CYCLES(H0)) dut0 (
    .clk(clk), .reset(reset), .avs_address(a_i[0]), .avs_read(rd_i[0]), .avs_write(wr_i[0]),
    .avs_writedata(wd_i[0]), .avs_waitrequest(wreq[0]), .avs_readdata(rdat[0]),
    .avs_readdatavalid(rdv[0]), .tcm_address_out(a_o[0]), .tcm_read_n_out(rd_n[0]),
    .tcm_write_n_out(wr_n[0]), .tcm_chipselect_n_out(cs_n[0]), .tcm_data_out(dout[0]),
    .tcm_data_outen(oen[0]), .tcm_data_in(din[0]));

  tcm_flash_sequencer #(.SETUP_CYCLES(S1), .WAIT_CYCLES(W1), .HOLD_CYCLES(H1)) dut1 (
    .clk(clk), .reset(reset), .avs_address(a_i[1]), .avs_read(rd_i[1]), .avs_write(wr_i[1]),
    .avs_writedata(wd_i[1]), .avs_waitrequest(wreq[1]), .avs_readdata(rdat[1]),
    .avs_readdatavalid(rdv[1]), .tcm_address_out(a_o[1]), .tcm_read_n_out(rd_n[1]),
    .tcm_write_n_out(wr_n[1]), .tcm_chipselect_n_out(cs_n[1]), .tcm_data_out(dout[1]),
    .tcm_data_outen(oen[1]), .tcm_data_in(din[1]));

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flash pad model (keyed by instance+address) and the independent scoreboard memory.
  logic [7:0] flash [logic [23:0]];
  logic [7:0] refm  [logic [23:0]];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic [23:0] k;
      k = {u[0], a_o[u]};
      if (!cs_n[u] && !wr_n[u]) flash[k] = dout[u];
      if (!cs_n[u] && !rd_n[u]) din[u] = flash.exists(k) ? flash[k] : 8'hFF;
      else din[u] = 8'hEE;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int u = 0; u < 2; u++) begin
        check("strobe_overlap", 64'(rd_n[u] | wr_n[u]), 64'(1));
        check("outen_in_read", 64'(!(oen[u] && !rd_n[u])), 64'(1));
      end
    end
  end

  task automatic preload(input int u, input logic [22:0] a, input logic [7:0] d);
    flash[{u[0], a}] = d;
    refm[{u[0], a}]  = d;
  endtask

  task automatic txn(input int u, input bit r, input bit w, input logic [22:0] a,
                     input logic [7:0] d, output int acc);
    int s, wt, h, t, n;
    bit isr, inwait, busy;
    logic [7:0] erd;
    logic [23:0] key;
    logic [28:0] expv, obsv;
    s = (u == 1) ? S1 : S0;
    wt = (u == 1) ? W1 : W0;
    h = (u == 1) ? H1 : H0;
    t = s + wt + h;
    isr = r;
    key = {u[0], a};
    n = 0;
    while (wreq[u] !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (wreq[u] !== 1'b0) begin
      check("accept_timeout", 64'(wreq[u]), 64'(0));
      acc = -1;
      return;
    end
    erd = refm.exists(key) ? refm[key] : 8'hFF;
    if (w && !r) refm[key] = d;
    a_i[u] = a; rd_i[u] = r; wr_i[u] = w; wd_i[u] = d;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    rd_i[u] = 1'b0; wr_i[u] = 1'b0; wd_i[u] = 8'($urandom); a_i[u] = 23'($urandom);
    for (int k = 1; k <= t + 1; k++) begin
      if (k > 1) @(negedge clk);
      inwait = (k > s) && (k <= s + wt);
      busy = (k <= t);
      expv = {!busy, !(inwait && isr), !(inwait && !isr), busy && !isr, busy,
              isr && (k == s + wt + 1), a};
      obsv = {cs_n[u], rd_n[u], wr_n[u], oen[u], wreq[u], rdv[u], a_o[u]};
      check($sformatf("u%0d_cycle%0d_pins", u, k), 64'(obsv), 64'(expv));
      if (isr && k == s + wt + 1) check("readdata", 64'(rdat[u]), 64'(erd));
      if (!isr && busy) check("write_data_out", 64'(dout[u]), 64'(d));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_prev;
    logic [22:0] ra;
    int u, op;
    for (int i = 0; i < 2; i++) begin
      a_i[i] = '0; rd_i[i] = 1'b0; wr_i[i] = 1'b0; wd_i[i] = '0; din[i] = 8'hEE;
    end

    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_state_u%0d", i),
            64'({cs_n[i], rd_n[i], wr_n[i], oen[i], wreq[i], rdv[i], a_o[i], rdat[i], dout[i]}),
            64'({1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 23'd0, 8'd0, 8'd0}));
    reset = 1'b0;
    #1;
    check("wreq_after_reset_u0", 64'(wreq[0]), 64'(0));
    check("wreq_after_reset_u1", 64'(wreq[1]), 64'(0));

    preload(0, 23'h12345, 8'hA5);
    txn(0, 1'b1, 1'b0, 23'h12345, 8'h00, acc);
    txn(0, 1'b0, 1'b1, 23'h7FFFFF, 8'h3C, acc);
    txn(0, 1'b1, 1'b0, 23'h7FFFFF, 8'h00, acc);
    preload(0, 23'h00100, 8'h5A);
    txn(0, 1'b1, 1'b1, 23'h00100, 8'h55, acc);
    txn(0, 1'b1, 1'b0, 23'h00100, 8'h00, acc);

    preload(1, 23'h00042, 8'h81);
    txn(1, 1'b1, 1'b0, 23'h00042, 8'h00, acc_prev);
    for (int i = 0; i < 3; i++) begin
      txn(1, 1'b1, 1'b0, 23'h00042, 8'h00, acc);
      check("back_to_back_gap", 64'(acc - acc_prev), 64'(S1 + W1 + H1 + 1));
      acc_prev = acc;
    end

    // Reset pulsed during the third WAIT cycle of a read.
    preload(0, 23'h00200, 8'hC3);
    a_i[0] = 23'h00200; rd_i[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_i[0] = 1'b0;
    repeat (S0 + 2) @(negedge clk);
    check("abort_pre_rd_n", 64'(rd_n[0]), 64'(0));
    #2 reset = 1'b1;
    #1;
    check("abort_pins_async",
          64'({cs_n[0], rd_n[0], wr_n[0], oen[0], wreq[0], rdv[0]}),
          64'({1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}));
    repeat (3) begin
      @(negedge clk);
      check("abort_in_reset", 64'({wreq[0], rdv[0], rd_n[0]}), 64'({1'b1, 1'b0, 1'b1}));
    end
    reset = 1'b0;
    #1;
    check("abort_wreq_release", 64'(wreq[0]), 64'(0));
    repeat (2) begin
      @(negedge clk);
      check("abort_no_rdv", 64'(rdv[0]), 64'(0));
    end
    txn(0, 1'b1, 1'b0, 23'h00200, 8'h00, acc);

    for (int i = 0; i < 50; i++) begin
      u = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 3));
      ra = 23'($urandom_range(0, 7)) * 23'h10001;
      txn(u, op != 1, op == 1 || op == 2, ra, 8'($urandom), acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tcm_flash_sequencer.md
TCM_FLASH_SEQUENCER -- requirements
Module: tcm_flash_sequencer

Interface
REQ-001 SHALL have parameters: SETUP_CYCLES, default 2, cycles with chip select low before the strobe asserts (range 1..15).
REQ-002 SHALL have parameter WAIT_CYCLES, default 6, cycles the read/write strobe is held low (range 1..15).
REQ-003 SHALL have parameter HOLD_CYCLES, default 2, cycles after the strobe deasserts with chip select and address held (range 0..15).
REQ-004 SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- avs_address  input  23  byte address from the Avalon-MM master.
- avs_read  input  1  read request.
- avs_write  input  1  write request.
- avs_writedata  input  8  write data.
- avs_waitrequest  output  1  high = command not accepted.
- avs_readdata  output  8  registered read data.
- avs_readdatavalid  output  1  one-cycle read-data qualifier.
- tcm_address_out  output  23  flash address to the conduit bridge.
- tcm_read_n_out  output  1  active-low output enable.
- tcm_write_n_out  output  1  active-low write enable.
- tcm_chipselect_n_out  output  1  active-low chip select.
- tcm_data_out  output  8  write data driven toward the pad.
- tcm_data_outen  output  1  pad driver enable; the bridge resolves the tristate.
- tcm_data_in  input  8  pad data for reads.

Function
REQ-005 SHALL implement an FSM with states IDLE, SETUP, WAIT and HOLD.
REQ-006 In IDLE, avs_waitrequest SHALL be 0. In every other state it SHALL be 1.
REQ-007 A command SHALL be accepted on a rising edge in IDLE with avs_read or avs_write high. On acceptance, address, writedata and type SHALL be latched and the FSM SHALL go to SETUP.
REQ-008 If avs_read and avs_write are both high, the block SHALL perform a read only.
REQ-009 SETUP SHALL last exactly SETUP_CYCLES cycles with these outputs: chipselect_n=0, address=latched value, read_n=1, write_n=1, outen=1 for writes and 0 for reads.
REQ-010 WAIT SHALL last exactly WAIT_CYCLES cycles with read_n=0 (read) or write_n=0 (write); all other outputs are as in SETUP.
REQ-011 For reads, tcm_data_in SHALL be captured into avs_readdata on the edge that ends WAIT.
REQ-012 avs_readdatavalid SHALL be 1 for exactly the single cycle following that edge.
REQ-013 HOLD SHALL last HOLD_CYCLES cycles with both strobes 1; chip select, address, tcm_data_out and outen are held.
REQ-014 When HOLD_CYCLES=0, the FSM SHALL go from WAIT directly to IDLE.
REQ-015 In IDLE, outputs SHALL be: chipselect_n=1, read_n=1, write_n=1, outen=0. Address and tcm_data_out retain their last values.
REQ-016 read_n and write_n SHALL never be low simultaneously.
REQ-017 Strobes SHALL never be low outside WAIT.
REQ-018 outen SHALL never be 1 during a read.
REQ-019 Read latency SHALL be SETUP_CYCLES+WAIT_CYCLES+1 cycles from the accepting edge to the edge sampling avs_readdatavalid=1.
REQ-020 The next command SHALL be acceptable SETUP_CYCLES+WAIT_CYCLES+HOLD_CYCLES+1 edges after the previous accepting edge (back-to-back, no idle gap).
REQ-021 The phase counter SHALL be 4 bits and reload on each state entry. A count reaching its terminal value SHALL not wrap or extend the phase.
REQ-022 Bus outputs SHALL be register-driven, with no combinational path from avs_* to tcm_*.

Reset
REQ-023 While reset=1, and asynchronously on its assertion, outputs SHALL be:
- chipselect_n=1, read_n=1, write_n=1
- outen=0, avs_readdatavalid=0, avs_waitrequest=1
- avs_readdata=0, tcm_address_out=0, tcm_data_out=0
- FSM state IDLE.
REQ-024 Reset asserted mid-transaction SHALL abort it immediately: no readdatavalid is produced for the aborted read, and no strobe glitch low.
REQ-025 avs_waitrequest SHALL be 0 in the first cycle after reset deasserts.

Verification
REQ-026 Single read, defaults, address 0x12345, tcm_data_in=0xA5 during WAIT:
- chipselect_n low 10 cycles, read_n low 6 cycles.
- avs_readdata=0xA5 with readdatavalid high at accept+9.
- waitrequest low again at accept+11.
REQ-027 Single write, address 0x7FFFFF, data 0x3C:
- write_n low exactly 6 cycles.
- outen=1 and tcm_data_out=0x3C for all 10 chip-select-low cycles.
- readdatavalid never asserted.
REQ-028 Read and write both asserted: read cycle only; write_n stays 1 throughout; outen stays 0.
REQ-029 HOLD_CYCLES=0, SETUP=1, WAIT=1, back-to-back reads: a new command is accepted every 3rd edge; readdatavalid occurs at accept+3.
REQ-030 Reset pulsed during the 3rd WAIT cycle of a read:
- All strobes deassert combinationally.
- No readdatavalid.
- waitrequest=1 during reset and 0 the cycle after release.
- A following read completes normally.
REQ-031 Random mixed traffic with a protocol checker on REQ-016..REQ-018 and a memory scoreboard: zero violations and read data matching the model.
